// File: rtl/spmm_tile_port_if.sv
`default_nettype none
// ============================================================================
//  Module   : spmm_tile_port_if
//  Purpose  : Dense-matrix link between the host-side tile port and the SpMM
//             accelerator. Carries the rhs transmit burst and the out receive
//             burst, each 4 tile rows per beat.
//  Signals  : rhs_ready  SpMM -> port   SpMM can accept an rhs burst
//             rhs_start  port -> SpMM   marks beat 0 of an rhs burst
//             rhs_data   port -> SpMM   4 x N x W beat, [i][j] = row i, col j
//             out_ready  SpMM -> port   result available
//             out_start  port -> SpMM   requests the result burst
//             out_data   SpMM -> port   4 x N x W result beat
//  Modports : master = tile port side, slave = SpMM side
//  Revision : 1.0  initial release
// ============================================================================
interface spmm_tile_port_if #(
    parameter int N = 16,
    parameter int W = 8
);
    logic                         rhs_ready;
    logic                         rhs_start;
    logic [3:0][N-1:0][W-1:0]     rhs_data;
    logic                         out_ready;
    logic                         out_start;
    logic [3:0][N-1:0][W-1:0]     out_data;

    modport master (
        input  rhs_ready,
        output rhs_start,
        output rhs_data,
        input  out_ready,
        output out_start,
        input  out_data
    );

    modport slave (
        output rhs_ready,
        input  rhs_start,
        input  rhs_data,
        output out_ready,
        input  out_start,
        output out_data
    );
endinterface
`default_nettype wire

// File: rtl/spmm_tile_port.sv
`default_nettype none
// ============================================================================
//  Module   : spmm_tile_port
//  Purpose  : Host-side companion to the SpMM dense ports. Holds an N x N rhs
//             tile and streams it to SpMM in 4-row beats; fetches SpMM's
//             result burst into an N x N buffer readable row by row.
//  Ports    : clock, reset          sync active-high reset
//             ld_valid/ld_row/ld_data   tile row write (ignored during TX)
//             tx_cmd / rx_cmd       start transmit / receive (pulses)
//             busy                  FSM not idle (combinational)
//             tx_done / rx_done     one-cycle completion pulses
//             cmd_drop              one-cycle pulse on a discarded command
//             spmm                  SpMM link (master modport)
//             rd_row / rd_data      combinational result-row read
//  Revision : 1.0  initial release
// ============================================================================
module spmm_tile_port #(
    parameter int N = 16,
    parameter int W = 8
) (
    input  wire logic                       clock,
    input  wire logic                       reset,
    input  wire logic                       ld_valid,
    input  wire logic [$clog2(N)-1:0]       ld_row,
    input  wire logic [N-1:0][W-1:0]        ld_data,
    input  wire logic                       tx_cmd,
    input  wire logic                       rx_cmd,
    output logic                            busy,
    output logic                            tx_done,
    output logic                            rx_done,
    output logic                            cmd_drop,
    spmm_tile_port_if.master                spmm,
    input  wire logic [$clog2(N)-1:0]       rd_row,
    output logic [N-1:0][W-1:0]             rd_data
);
    localparam int BEATS = N / 4;
    localparam int RW    = $clog2(N);
    // A single-beat burst still needs a 1-bit register; it simply never
    // leaves 0 because the last-beat test is always true.
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] TX_WAIT  = 3'd1;
    localparam logic [2:0] TX_BURST = 3'd2;
    localparam logic [2:0] RX_WAIT  = 3'd3;
    localparam logic [2:0] RX_BURST = 3'd4;

    logic [2:0]               state;
    logic [CW-1:0]            beat;
    logic [CW-1:0]            beat_next;
    logic [CW-1:0]            tx_sel;
    logic                     last_beat;
    logic [3:0][N-1:0][W-1:0] beat_rows;
    logic [N-1:0][W-1:0]      tile   [N];
    logic [N-1:0][W-1:0]      result [N];

    assign busy      = (state != IDLE);
    assign last_beat = (beat == CW'(BEATS - 1));
    assign beat_next = last_beat ? '0 : beat + CW'(1);
    // Output register is loaded one beat ahead: beat 0 on the WAIT exit,
    // beat k+1 while beat k is on the bus.
    assign tx_sel    = (state == TX_BURST) ? beat_next : '0;

    always_comb begin
        beat_rows = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (tx_sel == CW'(b)) begin
                for (int i = 0; i < 4; i++) begin
                    beat_rows[i] = tile[4*b + i];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            beat           <= '0;
            tx_done        <= 1'b0;
            rx_done        <= 1'b0;
            cmd_drop       <= 1'b0;
            spmm.rhs_start <= 1'b0;
            spmm.out_start <= 1'b0;
            spmm.rhs_data  <= '0;
        end else begin
            tx_done        <= 1'b0;
            rx_done        <= 1'b0;
            cmd_drop       <= 1'b0;
            spmm.rhs_start <= 1'b0;
            spmm.out_start <= 1'b0;
            spmm.rhs_data  <= '0;
            case (state)
                IDLE: begin
                    if (tx_cmd) begin
                        state    <= TX_WAIT;
                        cmd_drop <= rx_cmd;
                    end else if (rx_cmd) begin
                        state <= RX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (spmm.rhs_ready) begin
                        state          <= TX_BURST;
                        beat           <= '0;
                        spmm.rhs_start <= 1'b1;
                        spmm.rhs_data  <= beat_rows;
                    end
                end
                TX_BURST: begin
                    beat <= beat_next;
                    if (last_beat) begin
                        state   <= IDLE;
                        tx_done <= 1'b1;
                    end else begin
                        spmm.rhs_data <= beat_rows;
                    end
                end
                RX_WAIT: begin
                    if (spmm.out_ready) begin
                        state          <= RX_BURST;
                        beat           <= '0;
                        spmm.out_start <= 1'b1;
                    end
                end
                RX_BURST: begin
                    beat <= beat_next;
                    if (last_beat) begin
                        state   <= IDLE;
                        rx_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (state != IDLE && (tx_cmd || rx_cmd)) begin
                cmd_drop <= 1'b1;
            end
        end
    end

    // Tile is frozen while a transmit is pending or in flight.
    always_ff @(posedge clock) begin
        if (ld_valid && state != TX_WAIT && state != TX_BURST) begin
            for (int r = 0; r < N; r++) begin
                if (ld_row == RW'(r)) begin
                    tile[r] <= ld_data;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < N; r++) begin
                result[r] <= '0;
            end
        end else if (state == RX_BURST) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat == CW'(b)) begin
                    for (int i = 0; i < 4; i++) begin
                        result[4*b + i] <= spmm.out_data[i];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < N; r++) begin
            if (rd_row == RW'(r)) begin
                rd_data = result[r];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_spmm_tile_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spmm_tile_port
//  Purpose  : Directed self-checking bench for spmm_tile_port (N=16, W=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_spmm_tile_port;
    localparam int N = 16;
    localparam int W = 8;

    logic                  clock;
    logic                  reset;
    logic                  ld_valid;
    logic [3:0]            ld_row;
    logic [N-1:0][W-1:0]   ld_data;
    logic                  tx_cmd;
    logic                  rx_cmd;
    logic                  busy;
    logic                  tx_done;
    logic                  rx_done;
    logic                  cmd_drop;
    logic [3:0]            rd_row;
    logic [N-1:0][W-1:0]   rd_data;

    int tests;
    int fails;

    spmm_tile_port_if #(.N(N), .W(W)) sif ();

    spmm_tile_port #(.N(N), .W(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .ld_valid (ld_valid),
        .ld_row   (ld_row),
        .ld_data  (ld_data),
        .tx_cmd   (tx_cmd),
        .rx_cmd   (rx_cmd),
        .busy     (busy),
        .tx_done  (tx_done),
        .rx_done  (rx_done),
        .cmd_drop (cmd_drop),
        .spmm     (sif),
        .rd_row   (rd_row),
        .rd_data  (rd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after each edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_out(input int k, input int base);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < N; j++) begin
                sif.out_data[i][j] = 8'(base + 4*k + i + j);
            end
        end
    endtask

    // Checks one rhs beat: start flag and two sample elements.
    task automatic check_beat(input string tag, input int k, input logic [7:0] e25,
                              input logic [7:0] e37);
        check({tag, "_start"}, 32'(sif.rhs_start), (k == 0) ? 32'd1 : 32'd0);
        check({tag, "_d25"},   32'(sif.rhs_data[2][5]), 32'(e25));
        check({tag, "_d37"},   32'(sif.rhs_data[3][7]), 32'(e37));
        check({tag, "_busy"},  32'(busy), 32'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        ld_valid = 1'b0;
        ld_row = '0;
        ld_data = '0;
        tx_cmd = 1'b0;
        rx_cmd = 1'b0;
        rd_row = '0;
        sif.rhs_ready = 1'b0;
        sif.out_ready = 1'b0;
        sif.out_data = '0;
        tick();
        tick();
        tick();

        // ---- reset state
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_tx_done",   32'(tx_done), 32'd0);
        check("rst_rx_done",   32'(rx_done), 32'd0);
        check("rst_cmd_drop",  32'(cmd_drop), 32'd0);
        check("rst_rhs_start", 32'(sif.rhs_start), 32'd0);
        check("rst_out_start", 32'(sif.out_start), 32'd0);
        check("rst_rhs_data",  32'(|sif.rhs_data), 32'd0);
        rd_row = 4'd13;
        #1;
        check("rst_rd13", 32'(|rd_data), 32'd0);
        reset = 1'b0;

        // ---- 1: load tile r*16+c; last row shares its cycle with tx_cmd
        for (int r = 0; r < N; r++) begin
            ld_valid = 1'b1;
            ld_row = 4'(r);
            for (int c = 0; c < N; c++) ld_data[c] = 8'(r*16 + c);
            tx_cmd = (r == N-1);
            tick();
        end
        ld_valid = 1'b0;
        tx_cmd = 1'b0;
        check("t1_wait_busy", 32'(busy), 32'd1);
        tick();
        check("t1_wait_nostart", 32'(sif.rhs_start), 32'd0);
        sif.rhs_ready = 1'b1;
        tick();
        sif.rhs_ready = 1'b0;
        check_beat("t1_b0", 0, 8'd37, 8'd55);
        tick();
        check_beat("t1_b1", 1, 8'd101, 8'd119);
        tick();
        check_beat("t1_b2", 2, 8'd165, 8'd183);
        tick();
        check_beat("t1_b3", 3, 8'd229, 8'd247);
        tick();
        check("t1_tx_done", 32'(tx_done), 32'd1);
        check("t1_busy0",   32'(busy), 32'd0);
        check("t1_rhs0",    32'(|sif.rhs_data), 32'd0);
        tick();
        check("t1_done_pulse", 32'(tx_done), 32'd0);

        // ---- 2: long TX_WAIT; a load during the wait is ignored
        tx_cmd = 1'b1;
        tick();
        tx_cmd = 1'b0;
        for (int c = 0; c < 20; c++) begin
            ld_valid = (c == 3);
            ld_row = 4'd2;
            ld_data = '1;
            check("t2_wait_busy",    32'(busy), 32'd1);
            check("t2_wait_nostart", 32'(sif.rhs_start), 32'd0);
            tick();
        end
        ld_valid = 1'b0;
        sif.rhs_ready = 1'b1;
        tick();
        sif.rhs_ready = 1'b0;
        check_beat("t2_b0", 0, 8'd37, 8'd55);
        tick();
        check_beat("t2_b1", 1, 8'd101, 8'd119);
        tick();
        tick();
        check_beat("t2_b3", 3, 8'd229, 8'd247);
        tick();
        check("t2_tx_done", 32'(tx_done), 32'd1);
        tick();

        // ---- 3: receive out_data[i][j] = 4k+i+j
        rx_cmd = 1'b1;
        tick();
        rx_cmd = 1'b0;
        check("t3_wait_busy", 32'(busy), 32'd1);
        sif.out_ready = 1'b1;
        tick();
        sif.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t3_out_start", 32'(sif.out_start), (k == 0) ? 32'd1 : 32'd0);
            check("t3_no_rx_done", 32'(rx_done), 32'd0);
            set_out(k, 0);
            tick();
        end
        sif.out_data = '0;
        check("t3_rx_done", 32'(rx_done), 32'd1);
        check("t3_busy0",   32'(busy), 32'd0);
        rd_row = 4'd13;
        #1;
        check("t3_rd13_e3", 32'(rd_data[3]), 32'd16);
        check("t3_rd13_e0", 32'(rd_data[0]), 32'd13);
        rd_row = 4'd0;
        #1;
        check("t3_rd0_e15", 32'(rd_data[15]), 32'd15);
        tick();
        check("t3_done_pulse", 32'(rx_done), 32'd0);

        // ---- 4: simultaneous commands, then tx_cmd during the burst
        tx_cmd = 1'b1;
        rx_cmd = 1'b1;
        tick();
        tx_cmd = 1'b0;
        rx_cmd = 1'b0;
        check("t4_drop", 32'(cmd_drop), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        tick();
        check("t4_drop_pulse", 32'(cmd_drop), 32'd0);
        check("t4_tx_wait",    32'(sif.rhs_start), 32'd0);
        sif.rhs_ready = 1'b1;
        tick();
        sif.rhs_ready = 1'b0;
        check_beat("t4_b0", 0, 8'd37, 8'd55);
        tx_cmd = 1'b1;
        tick();
        tx_cmd = 1'b0;
        check("t4_drop_burst", 32'(cmd_drop), 32'd1);
        check_beat("t4_b1", 1, 8'd101, 8'd119);
        tick();
        check("t4_drop_clear", 32'(cmd_drop), 32'd0);
        check_beat("t4_b2", 2, 8'd165, 8'd183);
        tick();
        check_beat("t4_b3", 3, 8'd229, 8'd247);
        tick();
        check("t4_tx_done", 32'(tx_done), 32'd1);

        // ---- 6: rx right after tx_done; load allowed during RX
        tick();
        rx_cmd = 1'b1;
        tick();
        rx_cmd = 1'b0;
        check("t6_rx_busy", 32'(busy), 32'd1);
        check("t6_no_drop", 32'(cmd_drop), 32'd0);
        ld_valid = 1'b1;
        ld_row = 4'd6;
        for (int c = 0; c < N; c++) ld_data[c] = 8'h5A;
        sif.out_ready = 1'b1;
        tick();
        ld_valid = 1'b0;
        sif.out_ready = 1'b0;
        check("t6_out_start", 32'(sif.out_start), 32'd1);
        for (int k = 0; k < 4; k++) begin
            set_out(k, 100);
            tick();
        end
        sif.out_data = '0;
        check("t6_rx_done", 32'(rx_done), 32'd1);
        rd_row = 4'd13;
        #1;
        check("t6_rd13_e3", 32'(rd_data[3]), 32'd116);
        tx_cmd = 1'b1;
        tick();
        tx_cmd = 1'b0;
        sif.rhs_ready = 1'b1;
        tick();
        sif.rhs_ready = 1'b0;
        check_beat("t6_b0", 0, 8'd37, 8'd55);
        tick();
        check_beat("t6_b1", 1, 8'h5A, 8'd119);
        tick();
        tick();
        tick();
        check("t6_tx_done", 32'(tx_done), 32'd1);
        check("t6_rd13_kept", 32'(rd_data[3]), 32'd116);
        tick();

        // ---- 5: reset during beat 2 of an RX burst
        rx_cmd = 1'b1;
        tick();
        rx_cmd = 1'b0;
        sif.out_ready = 1'b1;
        tick();
        sif.out_ready = 1'b0;
        set_out(0, 50);
        tick();
        set_out(1, 50);
        tick();
        set_out(2, 50);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sif.out_data = '0;
        check("t5_busy0",      32'(busy), 32'd0);
        check("t5_out_start0", 32'(sif.out_start), 32'd0);
        check("t5_no_rx_done", 32'(rx_done), 32'd0);
        for (int r = 0; r < 8; r++) begin
            rd_row = 4'(r);
            #1;
            check("t5_rd_clear", 32'(|rd_data), 32'd0);
        end
        tick();
        check("t5_still_no_done", 32'(rx_done), 32'd0);
        check("t5_idle",          32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
